// File: rtl/sdram_arbit.sv
// sdram_arbit: central SDRAM bus arbiter. Holds the bus for init, then grants
// refresh / write / read sub-blocks one at a time and muxes the owner onto the pins.
module sdram_arbit (
  input  logic        sclk,
  input  logic        s_rst_n,
  // init sub-block
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        flag_init_end,
  // auto-refresh sub-block
  input  logic        ref_req,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic        flag_ref_end,
  output logic        ref_en,
  // write sub-block
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [12:0] wr_addr,
  input  logic        flag_wr_end,
  output logic        wr_en,
  // read sub-block
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [12:0] rd_addr,
  input  logic        flag_rd_end,
  output logic        rd_en,
  // SDRAM pins
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr
);

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned ADDR_W = 13;
  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ref_en_nxt;
  logic               wr_en_nxt;
  logic               rd_en_nxt;
  logic               last_wr;
  logic               last_wr_nxt;
  logic [CMD_W-1:0]   cmd_c;

  // State, grant pulses and write/read fairness flag
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state   <= ST_INIT;
      ref_en  <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      ref_en  <= ref_en_nxt;
      wr_en   <= wr_en_nxt;
      rd_en   <= rd_en_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Next state and grant decision; grants only fire when leaving ARBIT
  always_comb begin
    state_nxt   = state;
    ref_en_nxt  = 1'b0;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    last_wr_nxt = last_wr;
    case (state)
      ST_INIT: begin
        if (flag_init_end) state_nxt = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (ref_req) begin
          state_nxt  = ST_AREF;
          ref_en_nxt = 1'b1;
        end else if (wr_req && (!rd_req || !last_wr)) begin
          // On a tie, write wins unless write was the last one granted
          state_nxt   = ST_WRITE;
          wr_en_nxt   = 1'b1;
          last_wr_nxt = 1'b1;
        end else if (rd_req) begin
          state_nxt   = ST_READ;
          rd_en_nxt   = 1'b1;
          last_wr_nxt = 1'b0;
        end
      end
      ST_AREF: begin
        if (flag_ref_end) state_nxt = ST_ARBIT;
      end
      ST_WRITE: begin
        if (flag_wr_end) state_nxt = ST_ARBIT;
      end
      ST_READ: begin
        if (flag_rd_end) state_nxt = ST_ARBIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Pin mux follows the current owner; NOP while arbitrating
  always_comb begin
    cmd_c      = CMD_NOP;
    sdram_bank = BANK_W'(0);
    sdram_addr = ADDR_W'(0);
    case (state)
      ST_INIT: begin
        cmd_c      = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd_c      = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        cmd_c      = wr_cmd;
        sdram_bank = wr_bank;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        cmd_c      = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd_c      = CMD_NOP;
        sdram_bank = BANK_W'(0);
        sdram_addr = ADDR_W'(0);
      end
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_c;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: randomized bench for sdram_arbit with an ownership-level reference model.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b1;
  logic [3:0]  init_cmd = 4'b0111;
  logic [12:0] init_addr = 13'd0;
  logic        flag_init_end = 1'b0;
  logic        ref_req = 1'b0;
  logic [3:0]  aref_cmd = 4'b0111;
  logic [12:0] aref_addr = 13'd0;
  logic        flag_ref_end = 1'b0;
  logic        ref_en;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_cmd = 4'b0111;
  logic [1:0]  wr_bank = 2'd0;
  logic [12:0] wr_addr = 13'd0;
  logic        flag_wr_end = 1'b0;
  logic        wr_en;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_cmd = 4'b0111;
  logic [1:0]  rd_bank = 2'd0;
  logic [12:0] rd_addr = 13'd0;
  logic        flag_rd_end = 1'b0;
  logic        rd_en;
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_addr;

  always #5 sclk = ~sclk;

  sdram_arbit dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .flag_ref_end(flag_ref_end), .ref_en(ref_en),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .flag_wr_end(flag_wr_end), .wr_en(wr_en),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .flag_rd_end(flag_rd_end), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
  );

  // Who owns the bus, from the bench's point of view
  localparam int OWN_INIT = 0;
  localparam int OWN_NONE = 1;
  localparam int OWN_REF  = 2;
  localparam int OWN_WR   = 3;
  localparam int OWN_RD   = 4;
  localparam int REF_LAT  = 8;
  localparam int BURST    = 6;

  int         m_owner = OWN_INIT;
  bit         m_prev_wr = 1'b0;
  logic [2:0] m_grant = 3'b000;
  int         n_run = 0;
  int         n_fail = 0;
  int         log_q[$];
  int         ref_cnt = 0;
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  bit         hold_wr = 1'b0;
  bit         hold_rd = 1'b0;
  bit         stray = 1'b0;
  bit         rnd_req = 1'b0;
  bit         fix_init = 1'b0;

  wire [21:0] obs = {ref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n,
                     sdram_we_n, sdram_bank, sdram_addr};

  // Expected {ref_en,wr_en,rd_en,cmd,bank,addr} for the modelled owner
  function automatic logic [21:0] exp_vec();
    logic [18:0] bus;
    case (m_owner)
      OWN_INIT: bus = {init_cmd, 2'b00, init_addr};
      OWN_REF:  bus = {aref_cmd, 2'b00, aref_addr};
      OWN_WR:   bus = {wr_cmd, wr_bank, wr_addr};
      OWN_RD:   bus = {rd_cmd, rd_bank, rd_addr};
      default:  bus = {4'b0111, 2'b00, 13'd0};
    endcase
    return {m_grant, bus};
  endfunction

  task automatic model_reset();
    m_owner   = OWN_INIT;
    m_prev_wr = 1'b0;
    m_grant   = 3'b000;
  endtask

  // One clock of the ownership model: the free bus goes to refresh first,
  // otherwise to the write/read requester that was served less recently.
  task automatic model_step();
    bit want_wr;
    if (!s_rst_n) begin
      model_reset();
      return;
    end
    m_grant = 3'b000;
    case (m_owner)
      OWN_INIT: if (flag_init_end) m_owner = OWN_NONE;
      OWN_NONE: begin
        want_wr = wr_req && !(rd_req && m_prev_wr);
        if (ref_req) begin
          m_owner = OWN_REF;
          m_grant = 3'b100;
        end else if (want_wr) begin
          m_owner = OWN_WR;
          m_grant = 3'b010;
          m_prev_wr = 1'b1;
        end else if (rd_req) begin
          m_owner = OWN_RD;
          m_grant = 3'b001;
          m_prev_wr = 1'b0;
        end
      end
      OWN_REF: if (flag_ref_end) m_owner = OWN_NONE;
      OWN_WR:  if (flag_wr_end) m_owner = OWN_NONE;
      OWN_RD:  if (flag_rd_end) m_owner = OWN_NONE;
      default: m_owner = OWN_INIT;
    endcase
  endtask

  // Advance to just after the next rising edge and log observed grants
  task automatic tick();
    @(posedge sclk);
    model_step();
    #1;
    if (ref_en) log_q.push_back(1);
    if (wr_en)  log_q.push_back(2);
    if (rd_en)  log_q.push_back(3);
  endtask

  // Sub-block behaviour: drop req after en, pulse end flag a fixed time after en
  task automatic drive();
    if (!fix_init) begin
      init_cmd  = 4'($urandom);
      init_addr = 13'($urandom);
    end
    aref_cmd  = 4'($urandom);
    aref_addr = 13'($urandom);
    wr_cmd    = 4'($urandom);
    wr_bank   = 2'($urandom);
    wr_addr   = 13'($urandom);
    rd_cmd    = 4'($urandom);
    rd_bank   = 2'($urandom);
    rd_addr   = 13'($urandom);
    if (ref_cnt > 0) begin ref_cnt--; flag_ref_end = (ref_cnt == 0); end
    else flag_ref_end = 1'b0;
    if (wr_cnt > 0) begin wr_cnt--; flag_wr_end = (wr_cnt == 0); end
    else flag_wr_end = 1'b0;
    if (rd_cnt > 0) begin rd_cnt--; flag_rd_end = (rd_cnt == 0); end
    else flag_rd_end = 1'b0;
    if (ref_en) begin ref_req = 1'b0; ref_cnt = REF_LAT; end
    if (wr_en) begin if (!hold_wr) wr_req = 1'b0; wr_cnt = BURST; end
    if (rd_en) begin if (!hold_rd) rd_req = 1'b0; rd_cnt = BURST; end
    if (stray) begin
      if ($urandom_range(0, 15) == 0) flag_ref_end = 1'b1;
      if ($urandom_range(0, 15) == 0) flag_wr_end = 1'b1;
      if ($urandom_range(0, 15) == 0) flag_rd_end = 1'b1;
    end
    if (rnd_req) begin
      if (!ref_req && ref_cnt == 0 && $urandom_range(0, 40) == 0) ref_req = 1'b1;
      if (!wr_req && wr_cnt == 0 && $urandom_range(0, 5) == 0) wr_req = 1'b1;
      if (!rd_req && rd_cnt == 0 && $urandom_range(0, 5) == 0) rd_req = 1'b1;
    end
  endtask

  task automatic test_reset();
    fix_init = 1'b1;
    init_cmd = 4'b0010;
    drive();
    #1 s_rst_n = 1'b0;
    model_reset();
    #2;
    n_run++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_state t=%0t: got %h want %h", $time, obs, exp_vec());
    end
    n_run++;
    if ({sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_pins: got cke=%b cmd=%b%b%b%b want cke=1 cmd=0010", sdram_cke,
               sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n);
    end
    @(negedge sclk);
    s_rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL init_hold cyc %0d: got %h want %h", i, obs, exp_vec());
      end
      drive();
    end
    flag_init_end = 1'b1;
    tick();
    n_run++;
    if (obs !== 22'({3'b000, 4'b0111, 15'd0})) begin
      n_fail++;
      $display("FAIL init_exit_nop: got %h want %h", obs, 22'({3'b000, 4'b0111, 15'd0}));
    end
    drive();
    fix_init = 1'b0;
  endtask

  task automatic test_refresh();
    int n_ref;
    log_q.delete();
    for (int k = 0; k < 4500; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL refresh cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
      if (k % 1500 == 0) ref_req = 1'b1;
    end
    n_ref = 0;
    foreach (log_q[i]) if (log_q[i] == 1) n_ref++;
    n_run++;
    if (n_ref != 3 || log_q.size() != 3) begin
      n_fail++;
      $display("FAIL refresh_count: got %0d ref grants of %0d total want 3 of 3",
               n_ref, log_q.size());
    end
  endtask

  task automatic test_ref_wr_same();
    log_q.delete();
    ref_req = 1'b1;
    wr_req  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL ref_wr_same cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
    end
    n_run++;
    if (log_q.size() != 2 || log_q[0] != 1 || log_q[1] != 2) begin
      n_fail++;
      $display("FAIL ref_wr_order: got %p want '{1,2}", log_q);
    end
  endtask

  task automatic test_ref_during_write();
    log_q.delete();
    wr_req = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL ref_in_write cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
      if (k == 2) rd_req = 1'b1;
      if (k == 3) ref_req = 1'b1;
    end
    n_run++;
    if (log_q.size() != 3 || log_q[0] != 2 || log_q[1] != 1 || log_q[2] != 3) begin
      n_fail++;
      $display("FAIL ref_in_write_order: got %p want '{2,1,3}", log_q);
    end
  endtask

  task automatic test_alternate();
    log_q.delete();
    hold_wr = 1'b1;
    hold_rd = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    for (int k = 0; k < 80; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL alternate cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
      if (k == 59) begin
        hold_wr = 1'b0;
        hold_rd = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
      end
    end
    n_run++;
    if (log_q.size() < 4 || log_q[0] != 2 || log_q[1] != 3 || log_q[2] != 2 || log_q[3] != 3) begin
      n_fail++;
      $display("FAIL alternate_order: got %p want '{2,3,2,3,...}", log_q);
    end
    for (int i = 1; i < log_q.size(); i++) begin
      n_run++;
      if (log_q[i] == log_q[i-1]) begin
        n_fail++;
        $display("FAIL alternate_repeat idx %0d: got %0d twice want alternation", i, log_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    log_q.delete();
    rd_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pre_reset cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
    end
    n_run++;
    if (m_owner != OWN_RD || log_q.size() != 1) begin
      n_fail++;
      $display("FAIL read_owned: got owner %0d grants %0d want owner %0d grants 1",
               m_owner, log_q.size(), OWN_RD);
    end
    #3;
    s_rst_n = 1'b0;
    flag_init_end = 1'b0;
    #1;
    model_reset();
    n_run++;
    if (obs !== exp_vec() || obs[21:19] !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs, exp_vec());
    end
    for (int k = 0; k < 14; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
      if (k == 1) begin
        #3;
        s_rst_n = 1'b1;
      end
      if (k == 4) flag_rd_end = 1'b1;
    end
    flag_init_end = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reinit cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
    end
  endtask

  task automatic test_random();
    rnd_req = 1'b1;
    stray   = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
    end
    rnd_req = 1'b0;
    stray   = 1'b0;
    ref_req = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_run++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain cyc %0d: got %h want %h", k, obs, exp_vec());
      end
      drive();
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_ref_wr_same();
    test_ref_during_write();
    test_alternate();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
